// File: rtl/fifo_unpacker_pkg.sv
// Shared types and size helpers for the FIFO word unpacker.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package fifo_unpacker_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_e;

    function automatic int calc_num_seg(input int data_bw, input int seg_bw);
        return data_bw / seg_bw;
    endfunction

    // A single-segment word still needs a one-bit counter so the datapath stays uniform.
    function automatic int calc_cnt_bw(input int num_seg);
        return (num_seg > 1) ? $clog2(num_seg) : 1;
    endfunction

endpackage

// File: rtl/fifo_unpacker_ctrl.sv
// Unpacker controller: next state, FIFO pop strobe and datapath load/shift enables.
// Latency: purely combinational; rd_dout follows empty/state in the same cycle.
// Backpressure: holds position while seg_ready is low in SEND; never pops while empty or mid-word.
module fifo_unpacker_ctrl
    import fifo_unpacker_pkg::*;
(
    input  logic   rst,
    input  state_e state_q,
    input  logic   empty,
    input  logic   seg_ready,
    input  logic   cnt_last,
    output state_e state_d,
    output logic   rd_dout,
    output logic   load_en,
    output logic   shift_en,
    output logic   cnt_clr
);

    always_comb begin
        state_d  = state_q;
        rd_dout  = 1'b0;
        load_en  = 1'b0;
        shift_en = 1'b0;
        cnt_clr  = 1'b0;
        if (rst) begin
            case (state_q)
                IDLE: begin
                    if (!empty) begin
                        rd_dout = 1'b1;
                        load_en = 1'b1;
                        cnt_clr = 1'b1;
                        state_d = SEND;
                    end
                end
                SEND: begin
                    // seg_valid is implied in SEND, so seg_ready alone means accept.
                    if (seg_ready) begin
                        if (!cnt_last) begin
                            shift_en = 1'b1;
                        end else begin
                            cnt_clr = 1'b1;
`ifdef FIFO_UNPACKER_PREFETCH_EN
                            if (!empty) begin
                                rd_dout = 1'b1;
                                load_en = 1'b1;
                            end else begin
                                state_d = IDLE;
                            end
`else
                            state_d = IDLE;
`endif
                        end
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

endmodule

// File: rtl/fifo_unpacker.sv
// Pops DATA_BW words from a FIFO and emits them as SEG_BW segments, LSB first (FIFO_UNPACKER_PREFETCH_EN: zero-bubble reload).
// Latency: one cycle from pop to first seg_valid; NUM_SEG+1 cycles/word, or NUM_SEG with prefetch.
// Backpressure: valid/ready on the segment side; output and counter hold while seg_ready is low.
module fifo_unpacker
    import fifo_unpacker_pkg::*;
#(
    parameter int DATA_BW = 8,
    parameter int SEG_BW  = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               empty,
    input  logic [DATA_BW-1:0] dout,
    output logic               rd_dout,
    output logic [SEG_BW-1:0]  seg_out,
    output logic               seg_valid,
    input  logic               seg_ready,
    output logic               seg_last,
    output logic               busy
);

    localparam int NUM_SEG = calc_num_seg(DATA_BW, SEG_BW);
    localparam int CNT_BW  = calc_cnt_bw(NUM_SEG);
    localparam logic [CNT_BW-1:0] CNT_LAST = CNT_BW'(NUM_SEG - 1);

    generate
        if ((SEG_BW < 1) || (SEG_BW > DATA_BW) || ((DATA_BW % SEG_BW) != 0)) begin : g_bw_check
            $error("fifo_unpacker: DATA_BW must be a non-zero multiple of SEG_BW");
        end
    endgenerate

    state_e             state_q, state_d;
    logic [DATA_BW-1:0] shreg_q, shreg_d;
    logic [CNT_BW-1:0]  cnt_q, cnt_d;

    logic cnt_last;
    logic load_en;
    logic shift_en;
    logic cnt_clr;

    assign cnt_last = (state_q == SEND) && (cnt_q == CNT_LAST);

    fifo_unpacker_ctrl u_ctrl (
        .rst       (rst),
        .state_q   (state_q),
        .empty     (empty),
        .seg_ready (seg_ready),
        .cnt_last  (cnt_last),
        .state_d   (state_d),
        .rd_dout   (rd_dout),
        .load_en   (load_en),
        .shift_en  (shift_en),
        .cnt_clr   (cnt_clr)
    );

    always_comb begin
        shreg_d = shreg_q;
        cnt_d   = cnt_q;
        if (load_en) begin
            shreg_d = dout;
        end else if (shift_en) begin
            shreg_d = shreg_q >> SEG_BW;
        end
        // The counter only wraps on a last-segment accept, via cnt_clr.
        if (cnt_clr) begin
            cnt_d = '0;
        end else if (shift_en) begin
            cnt_d = cnt_q + CNT_BW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            shreg_q <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            shreg_q <= shreg_d;
            cnt_q   <= cnt_d;
        end
    end

    assign seg_valid = (state_q == SEND);
    assign seg_last  = cnt_last;
    assign busy      = (state_q != IDLE);
    assign seg_out   = shreg_q[SEG_BW-1:0];

    a_no_underflow : assert property (@(posedge clk) disable iff (!rst) !(rd_dout && empty));

endmodule

// File: tb/tb_fifo_unpacker.sv
// Scoreboarded bench for fifo_unpacker: upstream FIFO modelled as a queue, expected segments
// derived from the LSB-first slicing rule and checked by an independent monitor.
module tb_fifo_unpacker;

    localparam int DATA_BW = 8;
    localparam int SEG_BW  = 2;
    localparam int NUM_SEG = DATA_BW / SEG_BW;
`ifdef FIFO_UNPACKER_PREFETCH_EN
    localparam int WORD_GAP = 1;
`else
    localparam int WORD_GAP = 2;
`endif

    logic               clk = 1'b0;
    logic               rst = 1'b0;
    logic               empty = 1'b1;
    logic [DATA_BW-1:0] dout = '0;
    logic               rd_dout;
    logic [SEG_BW-1:0]  seg_out;
    logic               seg_valid;
    logic               seg_ready = 1'b0;
    logic               seg_last;
    logic               busy;

    always #5 clk = ~clk;

    fifo_unpacker #(.DATA_BW(DATA_BW), .SEG_BW(SEG_BW)) dut (
        .clk       (clk),
        .rst       (rst),
        .empty     (empty),
        .dout      (dout),
        .rd_dout   (rd_dout),
        .seg_out   (seg_out),
        .seg_valid (seg_valid),
        .seg_ready (seg_ready),
        .seg_last  (seg_last),
        .busy      (busy)
    );

    typedef struct packed {
        logic [SEG_BW-1:0] seg;
        logic              last;
    } exp_t;

    logic [DATA_BW-1:0] up_q[$];
    exp_t               exp_q[$];
    int                 acc_cyc[$];

    int   n_checks = 0;
    int   n_pass = 0;
    int   pop_cnt = 0;
    int   acc_cnt = 0;
    int   cyc = 0;
    int   ready_mode = 0;   // 0: always ready, 1: never ready, 2: random
    logic rd_seen = 1'b0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, got, exp);
    endtask

    // Reference model: word split into NUM_SEG slices, least significant slice first.
    task automatic push_word(input logic [DATA_BW-1:0] w);
        exp_t e;
        up_q.push_back(w);
        for (int i = 0; i < NUM_SEG; i++) begin
            e.seg  = SEG_BW'(w >> (i * SEG_BW));
            e.last = (i == NUM_SEG - 1);
            exp_q.push_back(e);
        end
    endtask

    // Upstream FIFO and downstream ready driver.
    always @(posedge clk) begin
        cyc++;
        if (rd_seen) begin
            if (up_q.size() > 0) void'(up_q.pop_front());
            pop_cnt++;
        end
        #1;
        empty = (up_q.size() == 0);
        dout  = empty ? '0 : up_q[0];
        case (ready_mode)
            0:       seg_ready = 1'b1;
            1:       seg_ready = 1'b0;
            default: seg_ready = ($urandom_range(0, 3) != 0);
        endcase
    end

    // Monitor / scoreboard.
    logic              prev_stall = 1'b0;
    logic              prev_rd = 1'b0;
    logic [SEG_BW-1:0] prev_seg = '0;
    logic              prev_last = 1'b0;

    always @(negedge clk) begin
        exp_t e;
        if (!rst) begin
            prev_stall = 1'b0;
            prev_rd    = 1'b0;
            rd_seen    = 1'b0;
        end else begin
            if (empty) chk("no_underflow_pop", 32'(rd_dout), 32'd0);
            if (prev_rd) chk("pop_to_valid_latency", 32'(seg_valid), 32'd1);
            if (prev_stall) begin
                chk("stall_hold_valid", 32'(seg_valid), 32'd1);
                chk("stall_hold_seg", 32'(seg_out), 32'(prev_seg));
                chk("stall_hold_last", 32'(seg_last), 32'(prev_last));
            end
            if (rd_dout && seg_valid) chk("pop_only_on_last_accept", 32'(seg_last && seg_ready), 32'd1);
            if (seg_valid && seg_ready) begin
                acc_cnt++;
                acc_cyc.push_back(cyc);
                if (exp_q.size() == 0) begin
                    n_checks++;
                    $display("FAIL unexpected_segment: got %0h expected none", seg_out);
                end else begin
                    e = exp_q.pop_front();
                    chk("seg_out", 32'(seg_out), 32'(e.seg));
                    chk("seg_last", 32'(seg_last), 32'(e.last));
                end
            end
            prev_stall = seg_valid && !seg_ready;
            prev_seg   = seg_out;
            prev_last  = seg_last;
            prev_rd    = rd_dout;
            rd_seen    = rd_dout;
        end
    end

    task automatic wait_drain(input string name);
        int n = 0;
        while ((exp_q.size() != 0 || up_q.size() != 0 || busy) && n < 3000) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        chk({name, "_drain_in_time"}, 32'(n < 3000), 32'd1);
    endtask

    task automatic check_outputs_zero(input string name);
        chk({name, "_rd_dout"}, 32'(rd_dout), 32'd0);
        chk({name, "_seg_valid"}, 32'(seg_valid), 32'd0);
        chk({name, "_seg_last"}, 32'(seg_last), 32'd0);
        chk({name, "_seg_out"}, 32'(seg_out), 32'd0);
        chk({name, "_busy"}, 32'(busy), 32'd0);
    endtask

    initial begin
        int base_pop;
        int base_acc;
        int n;
        int partial;

        // Reset state.
        repeat (3) @(posedge clk);
        #1;
        check_outputs_zero("reset");
        @(posedge clk);
        #2 rst = 1'b1;

        // Single word, always ready.
        base_pop = pop_cnt;
        acc_cyc.delete();
        push_word(8'hB4);
        wait_drain("t1");
        chk("t1_single_pop", 32'(pop_cnt - base_pop), 32'd1);
        chk("t1_accept_count", 32'(acc_cyc.size()), 32'd4);
        if (acc_cyc.size() == 4) chk("t1_back_to_back", 32'(acc_cyc[3] - acc_cyc[0]), 32'd3);

        // Stall on the first segment for three cycles.
        ready_mode = 1;
        push_word(8'hB4);
        n = 0;
        while (!seg_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("t2_valid_seen", 32'(seg_valid), 32'd1);
        base_pop = pop_cnt;
        for (int i = 0; i < 3; i++) begin
            chk("t2_stall_seg", 32'(seg_out), 32'd0);
            chk("t2_stall_rd", 32'(rd_dout), 32'd0);
            if (i < 2) @(negedge clk);
        end
        ready_mode = 0;
        wait_drain("t2");
        chk("t2_no_extra_pop", 32'(pop_cnt - base_pop), 32'd0);

        // Two queued words: gap between words depends on prefetch.
        acc_cyc.delete();
        push_word(8'h1B);
        push_word(8'hE4);
        wait_drain("t3");
        chk("t3_accept_count", 32'(acc_cyc.size()), 32'd8);
        if (acc_cyc.size() == 8) begin
            chk("t3_word_gap", 32'(acc_cyc[4] - acc_cyc[3]), 32'(WORD_GAP));
            chk("t3_total_span", 32'(acc_cyc[7] - acc_cyc[0]), 32'(6 + WORD_GAP));
        end

        // Idle with an empty FIFO.
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("t4_idle_rd", 32'(rd_dout), 32'd0);
            chk("t4_idle_valid", 32'(seg_valid), 32'd0);
            chk("t4_idle_busy", 32'(busy), 32'd0);
        end

        // Reset mid-word, then a fresh word starts at segment 0.
        base_acc = acc_cnt;
        push_word(8'hB4);
        n = 0;
        while (acc_cnt < base_acc + 2 && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("t5_two_accepted", 32'(acc_cnt - base_acc), 32'd2);
        @(posedge clk);
        #2 rst = 1'b0;
        partial = pop_cnt * NUM_SEG - acc_cnt;
        for (int i = 0; i < partial; i++) if (exp_q.size() > 0) void'(exp_q.pop_front());
        acc_cnt += partial;
        #1;
        check_outputs_zero("t5_in_reset");
        push_word(8'hA7);
        @(posedge clk);
        #2;
        chk("t5_reset_empty_seen", 32'(empty), 32'd0);
        chk("t5_reset_no_pop", 32'(rd_dout), 32'd0);
        @(posedge clk);
        #2 rst = 1'b1;
        wait_drain("t5");

        // Randomized traffic with random backpressure.
        ready_mode = 2;
        for (int i = 0; i < 40; i++) begin
            push_word(DATA_BW'($urandom));
            repeat ($urandom_range(0, 6)) @(posedge clk);
        end
        wait_drain("t6");
        ready_mode = 0;

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
